// File: rtl/rw_scheduler_if.sv
// rw_scheduler_if: groups the queue-status inputs and the command/pop outputs of rw_scheduler.
// Latency: none, wires only.
// Backpressure: ready travels from the downstream address pipeline to the scheduler.
// Ports: master = scheduler view (status in, commands out); slave = queue/pipeline view.
interface rw_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 5
);
  logic              rd_mt;
  logic              wr_mt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] rd_adrs;
  logic [ADDR_W-1:0] wr_adrs;
  logic              ready;
  logic              rd_ld;
  logic              wr_ld;
  logic              cmd_valid;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_adrs;
  logic              turn_busy;

  modport master (
    input  rd_mt, wr_mt, wr_cnt, rd_adrs, wr_adrs, ready,
    output rd_ld, wr_ld, cmd_valid, cmd_op, cmd_adrs, turn_busy
  );

  modport slave (
    output rd_mt, wr_mt, wr_cnt, rd_adrs, wr_adrs, ready,
    input  rd_ld, wr_ld, cmd_valid, cmd_op, cmd_adrs, turn_busy
  );
endinterface

// File: rtl/rw_scheduler.sv
// rw_scheduler: picks read or write mode for a pair of request queues and issues one head address per command.
// Latency: a command appears one cycle after the deciding edge; direction changes add TURN_CYC turnaround cycles.
// Backpressure: ready=0 freezes issue and mode decisions; only the turnaround countdown keeps running.
// Ports: clk (rising edge), rst (async active-low), bus (rw_scheduler_if.master: status in, commands out).
// Optional: define RW_STARVE_GUARD_EN to force a write turn after STARVE_MAX consecutive reads while writes wait.
module rw_scheduler #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 5,
  parameter int WR_HI_WM   = 12,
  parameter int WR_LO_WM   = 4,
  parameter int TURN_CYC   = 3,
  parameter int STARVE_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  rw_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  localparam logic [CNT_W-1:0] HI_WM = CNT_W'(WR_HI_WM);
  localparam logic [CNT_W-1:0] LO_WM = CNT_W'(WR_LO_WM);
  localparam int               TC_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  // Catch watermark inversion and degenerate limits at elaboration.
  if (WR_LO_WM >= WR_HI_WM || TURN_CYC < 1 || STARVE_MAX < 1) begin : g_cfg_check
    $error("rw_scheduler: illegal watermark, turnaround or starvation configuration");
  end

  state_t            state;
  logic              target;    // direction to enter once TURN finishes (1 = write)
  logic              last_op;
  logic [TC_W-1:0]   turn_cnt;
  logic              rd_ld_q, wr_ld_q, cmd_valid_q, cmd_op_q, turn_busy_q;
  logic [ADDR_W-1:0] cmd_adrs_q;

  logic hi_hit, lo_hit, both_mt, starve_hit, rd_leave, wr_leave, idle_wr;
  logic go, go_dir, go_idle, issue;

`ifdef RW_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_cnt;
  assign starve_hit = !bus.wr_mt && (starve_cnt >= SC_W'(STARVE_MAX));
`else
  assign starve_hit = 1'b0;
`endif

  assign hi_hit   = (bus.wr_cnt >= HI_WM);
  assign lo_hit   = (bus.wr_cnt <= LO_WM);
  assign both_mt  = bus.rd_mt && bus.wr_mt;
  assign rd_leave = hi_hit || (bus.rd_mt && !bus.wr_mt) || starve_hit;
  assign wr_leave = bus.wr_mt || (lo_hit && !bus.rd_mt);
  assign idle_wr  = !bus.wr_mt && (bus.rd_mt || hi_hit);

  // Decisions for this edge. The cycle after an issue (cmd_valid high) is a dead
  // cycle: the queues are still popping, so their status is not trusted yet.
  // Exit conditions win over issue so a hot read stream cannot hold off a drain.
  always_comb begin
    go      = 1'b0;
    go_dir  = 1'b0;
    go_idle = 1'b0;
    issue   = 1'b0;
    if (bus.ready) begin
      case (state)
        IDLE: begin
          if (idle_wr) begin
            go     = 1'b1;
            go_dir = 1'b1;
          end else if (!bus.rd_mt) begin
            go = 1'b1;
          end
        end
        READ: begin
          if (!cmd_valid_q) begin
            if (both_mt) begin
              go_idle = 1'b1;
            end else if (rd_leave) begin
              go     = 1'b1;
              go_dir = 1'b1;
            end else begin
              issue = 1'b1;
            end
          end
        end
        WRITE: begin
          if (!cmd_valid_q) begin
            if (both_mt) begin
              go_idle = 1'b1;
            end else if (wr_leave) begin
              go = 1'b1;
            end else begin
              issue = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      target      <= 1'b0;
      last_op     <= 1'b0;
      turn_cnt    <= '0;
      rd_ld_q     <= 1'b0;
      wr_ld_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 1'b0;
      cmd_adrs_q  <= '0;
      turn_busy_q <= 1'b0;
`ifdef RW_STARVE_GUARD_EN
      starve_cnt  <= '0;
`endif
    end else begin
      rd_ld_q     <= 1'b0;
      wr_ld_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      if (state == TURN) begin
        // Runs regardless of ready so the bus turnaround time stays fixed.
        if (turn_cnt == '0) begin
          state       <= target ? WRITE : READ;
          turn_busy_q <= 1'b0;
        end else begin
          turn_cnt <= turn_cnt - TC_W'(1);
        end
      end else if (go_idle) begin
        state <= IDLE;
      end else if (go) begin
        if (go_dir != last_op) begin
          state       <= TURN;
          target      <= go_dir;
          turn_cnt    <= TC_W'(TURN_CYC - 1);
          turn_busy_q <= 1'b1;
        end else begin
          state <= go_dir ? WRITE : READ;
        end
      end else if (issue) begin
        cmd_valid_q <= 1'b1;
        cmd_op_q    <= (state == WRITE);
        last_op     <= (state == WRITE);
        cmd_adrs_q  <= (state == WRITE) ? bus.wr_adrs : bus.rd_adrs;
        rd_ld_q     <= (state == READ);
        wr_ld_q     <= (state == WRITE);
      end
`ifdef RW_STARVE_GUARD_EN
      // Counts reads issued while writes sit waiting; saturates at the limit.
      if (bus.ready) begin
        if (bus.wr_mt) begin
          starve_cnt <= '0;
        end else if (issue && state == WRITE) begin
          starve_cnt <= '0;
        end else if (issue && state == READ && starve_cnt != SC_W'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + SC_W'(1);
        end
      end
`endif
    end
  end

  assign bus.rd_ld     = rd_ld_q;
  assign bus.wr_ld     = wr_ld_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_adrs  = cmd_adrs_q;
  assign bus.turn_busy = turn_busy_q;

endmodule

// File: tb/tb_rw_scheduler.sv
// tb_rw_scheduler: directed vector table, reset/turnaround sequences and a randomized run against a reference model.
// Latency: expected outputs are those visible one clock after the inputs of each step are applied.
// Backpressure: ready is toggled both in the table and at random.
module tb_rw_scheduler;
  localparam int ADDR_W     = 32;
  localparam int CNT_W      = 5;
  localparam int WR_HI_WM   = 12;
  localparam int WR_LO_WM   = 4;
  localparam int TURN_CYC   = 3;
  localparam int STARVE_MAX = 8;

  localparam int M_IDLE = 0;
  localparam int M_RD   = 1;
  localparam int M_WR   = 2;
  localparam int M_TURN = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  rw_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  rw_scheduler #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .WR_HI_WM(WR_HI_WM), .WR_LO_WM(WR_LO_WM),
    .TURN_CYC(TURN_CYC), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rd_mt;
    int          wr_cnt;
    bit          ready;
    logic [31:0] rd_a;
    logic [31:0] wr_a;
    bit          cv;
    bit          rl;
    bit          wl;
    bit          op;
    logic [31:0] ad;
    bit          tb;
  } vec_t;

  vec_t vt[25];

  // Reference model: the mode the scheduler is in, how many turnaround cycles remain,
  // and the last direction actually issued.
  int          m_mode;
  bit          m_target;
  bit          m_last;
  int          m_turn_left;
  int          m_starve;
  bit          e_cv, e_rl, e_wl, e_op, e_tb;
  logic [31:0] e_ad;

  // Starvation-sequence bookkeeping.
  int nreads, nturn;
  bit seen_turn, got_write;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic drive(input bit rmt, input int wc, input bit rdy, input logic [31:0] ra,
                       input logic [31:0] wa);
    bus.rd_mt   = rmt;
    bus.wr_cnt  = CNT_W'(wc);
    bus.wr_mt   = (wc == 0);
    bus.ready   = rdy;
    bus.rd_adrs = ra;
    bus.wr_adrs = wa;
  endtask

  task automatic cmp_out(input string pfx, input bit cv, input bit rl, input bit wl,
                         input bit op, input logic [31:0] ad, input bit tb);
    chk({pfx, " cmd_valid"}, 32'(bus.cmd_valid), 32'(cv));
    chk({pfx, " rd_ld"}, 32'(bus.rd_ld), 32'(rl));
    chk({pfx, " wr_ld"}, 32'(bus.wr_ld), 32'(wl));
    chk({pfx, " turn_busy"}, 32'(bus.turn_busy), 32'(tb));
    if (cv) begin
      chk({pfx, " cmd_op"}, 32'(bus.cmd_op), 32'(op));
      chk({pfx, " cmd_adrs"}, bus.cmd_adrs, ad);
    end
  endtask

  // Holds reset for two cycles, checks the reset values, releases on a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset cmd_op", 32'(bus.cmd_op), 32'h0);
    chk("reset cmd_adrs", bus.cmd_adrs, 32'h0);
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_target = 1'b0; m_last = 1'b0; m_turn_left = 0; m_starve = 0;
    e_cv = 1'b0; e_rl = 1'b0; e_wl = 1'b0; e_op = 1'b0; e_tb = 1'b0; e_ad = 32'h0;
  endtask

  // Going to a mode: a change of direction costs TURN_CYC dead cycles first.
  task automatic model_enter(input bit to_write);
    if (to_write != m_last) begin
      m_mode      = M_TURN;
      m_target    = to_write;
      m_turn_left = TURN_CYC;
    end else begin
      m_mode = to_write ? M_WR : M_RD;
    end
  endtask

  task automatic model_step();
    bit busy_cycle;
    bit starving;
    bit rd_go;
    bit wr_go;
    int wc;
    busy_cycle = e_cv;
    rd_go = 1'b0;
    wr_go = 1'b0;
    wc = int'(bus.wr_cnt);
`ifdef RW_STARVE_GUARD_EN
    starving = !bus.wr_mt && (m_starve >= STARVE_MAX);
`else
    starving = 1'b0;
`endif
    e_cv = 1'b0; e_rl = 1'b0; e_wl = 1'b0;
    if (m_mode == M_TURN) begin
      m_turn_left = m_turn_left - 1;
      if (m_turn_left == 0) m_mode = m_target ? M_WR : M_RD;
    end else if (bus.ready) begin
      if (m_mode == M_IDLE) begin
        if (!bus.wr_mt && (bus.rd_mt || wc >= WR_HI_WM)) model_enter(1'b1);
        else if (!bus.rd_mt) model_enter(1'b0);
      end else if (!busy_cycle) begin
        if (bus.rd_mt && bus.wr_mt) m_mode = M_IDLE;
        else if (m_mode == M_RD) begin
          if (wc >= WR_HI_WM || (bus.rd_mt && !bus.wr_mt) || starving) model_enter(1'b1);
          else rd_go = 1'b1;
        end else begin
          if (bus.wr_mt || (wc <= WR_LO_WM && !bus.rd_mt)) model_enter(1'b0);
          else wr_go = 1'b1;
        end
      end
      if (bus.wr_mt || wr_go) m_starve = 0;
      else if (rd_go && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end
    if (rd_go || wr_go) begin
      e_cv = 1'b1; e_rl = rd_go; e_wl = wr_go; e_op = wr_go;
      e_ad = wr_go ? bus.wr_adrs : bus.rd_adrs;
      m_last = wr_go;
    end
    e_tb = (m_mode == M_TURN);
  endtask

  initial begin
    int wc;
    // rd_mt, wr_cnt, ready, rd_adrs, wr_adrs | cmd_valid, rd_ld, wr_ld, cmd_op, cmd_adrs, turn_busy
    vt[0]  = '{0, 0, 1, 32'h100, 32'h200, 0, 0, 0, 0, 32'h0,   0};
    vt[1]  = '{0, 0, 1, 32'h100, 32'h200, 1, 1, 0, 0, 32'h100, 0};
    vt[2]  = '{0, 11, 1, 32'h104, 32'h200, 0, 0, 0, 0, 32'h0,  0};
    vt[3]  = '{0, 11, 1, 32'h104, 32'h200, 1, 1, 0, 0, 32'h104, 0};
    vt[4]  = '{0, 12, 1, 32'h108, 32'h200, 0, 0, 0, 0, 32'h0,  0};
    vt[5]  = '{0, 12, 1, 32'h108, 32'h200, 0, 0, 0, 0, 32'h0,  1};
    vt[6]  = '{0, 12, 1, 32'h108, 32'h200, 0, 0, 0, 0, 32'h0,  1};
    vt[7]  = '{0, 12, 1, 32'h108, 32'h200, 0, 0, 0, 0, 32'h0,  1};
    vt[8]  = '{0, 12, 1, 32'h108, 32'h200, 0, 0, 0, 0, 32'h0,  0};
    vt[9]  = '{0, 12, 1, 32'h108, 32'h200, 1, 0, 1, 1, 32'h200, 0};
    vt[10] = '{0, 4, 1, 32'h10C, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[11] = '{0, 4, 1, 32'h10C, 32'h204, 0, 0, 0, 0, 32'h0,   1};
    vt[12] = '{0, 4, 1, 32'h10C, 32'h204, 0, 0, 0, 0, 32'h0,   1};
    vt[13] = '{0, 4, 1, 32'h10C, 32'h204, 0, 0, 0, 0, 32'h0,   1};
    vt[14] = '{0, 4, 1, 32'h10C, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[15] = '{0, 4, 1, 32'h10C, 32'h204, 1, 1, 0, 0, 32'h10C, 0};
    vt[16] = '{0, 4, 0, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[17] = '{0, 4, 0, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[18] = '{0, 4, 0, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[19] = '{0, 4, 0, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[20] = '{0, 4, 0, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[21] = '{0, 4, 1, 32'h110, 32'h204, 1, 1, 0, 0, 32'h110, 0};
    vt[22] = '{1, 0, 1, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[23] = '{1, 0, 1, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   0};
    vt[24] = '{1, 3, 1, 32'h110, 32'h204, 0, 0, 0, 0, 32'h0,   1};

    // Directed table: first read, read->write on high watermark, drain to low
    // watermark, ready stall, both-empty idle, idle->write turnaround.
    drive(1'b0, 0, 1'b1, 32'h100, 32'h200);
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].rd_mt, vt[i].wr_cnt, vt[i].ready, vt[i].rd_a, vt[i].wr_a);
      @(negedge clk);
      cmp_out($sformatf("vec%0d", i), vt[i].cv, vt[i].rl, vt[i].wl, vt[i].op, vt[i].ad, vt[i].tb);
    end

    // Reset during the second turnaround cycle, then a read restart with no turnaround.
    drive(1'b0, 0, 1'b1, 32'h300, 32'h400);
    @(posedge clk);
    #2;
    chk("turn cycle 2 turn_busy", 32'(bus.turn_busy), 32'h1);
    rst = 1'b0;
    #1;
    cmp_out("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("async reset cmd_adrs", bus.cmd_adrs, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_out("restart idle->read", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    cmp_out("restart first read", 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b0);

`ifdef RW_STARVE_GUARD_EN
    // Writes below the high watermark still get served after STARVE_MAX reads.
    drive(1'b0, 2, 1'b1, 32'h500, 32'h600);
    do_reset();
    nreads = 0; nturn = 0; seen_turn = 1'b0; got_write = 1'b0;
    for (int c = 0; c < 80 && !got_write; c++) begin
      @(negedge clk);
      if (bus.turn_busy) begin
        if (!seen_turn) chk("starve reads before turn", 32'(nreads), 32'(STARVE_MAX));
        seen_turn = 1'b1;
        nturn++;
      end
      if (bus.rd_ld) nreads++;
      if (bus.cmd_valid && bus.cmd_op) got_write = 1'b1;
    end
    chk("starve turn cycles", 32'(nturn), 32'(TURN_CYC));
    chk("starve write issued", 32'(got_write), 32'h1);
`endif

    // Randomized run against the reference model.
    wc = 0;
    drive(1'b1, 0, 1'b1, 32'h0, 32'h0);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0: if (wc > 0) wc--;
        1: if (wc < 16) wc++;
        default: ;
      endcase
      drive($urandom_range(0, 3) == 0, wc, $urandom_range(0, 7) != 0, $urandom, $urandom);
      model_step();
      @(negedge clk);
      cmp_out($sformatf("rand%0d", c), e_cv, e_rl, e_wl, e_op, e_ad, e_tb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
